// File: rtl/dac_playback_sequencer.sv
// Playback sequencer: drives DAC sample-buffer read strobes/addresses from a latched config.
// Latency: trigger sampled at edge T gives first rd_en at T+1; all outputs registered.
// Backpressure: cfg_ready only in IDLE; trigger/stop are levels; DAC_SEQ_REPEAT_EN adds cfg_repeat.
module dac_playback_sequencer #(
    parameter int ADDR_W = 16,
    parameter int DIV_W  = 16
) (
    input  logic              dac_clk,
    input  logic              resetn,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_start,
    input  logic [ADDR_W-1:0] cfg_len,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_cont,
`ifdef DAC_SEQ_REPEAT_EN
    input  logic [7:0]        cfg_repeat,
`endif
    input  logic              trigger,
    input  logic              stop,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic              done,
    output logic              pass_end
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [DIV_W-1:0]  DIV_ONE  = 1;

    state_t            state;
    logic [ADDR_W-1:0] start_q;
    logic [ADDR_W-1:0] len_q;
    logic [DIV_W-1:0]  div_q;
    logic              cont_q;
    logic [ADDR_W-1:0] idx;
    logic [DIV_W-1:0]  div_cnt;
    // Set with the final strobe of a one-shot run; the next edge enters DONE.
    logic              fin;

    logic [ADDR_W-1:0] sidx;
    logic              strobe;
    logic              last_smp;
    logic              pass_final;

`ifdef DAC_SEQ_REPEAT_EN
    logic [7:0]        rep_q;
    logic [7:0]        pcnt;
    logic [7:0]        spcnt;
`endif

    // Strobe decision for this edge; on the trigger edge the index and pass count read as zero.
    always_comb begin
        sidx     = (state == ARMED) ? '0 : idx;
        last_smp = (sidx == len_q);
        strobe   = !stop && (((state == ARMED) && trigger) ||
                             ((state == RUN) && !fin && (div_cnt == div_q)));
`ifdef DAC_SEQ_REPEAT_EN
        spcnt      = (state == ARMED) ? 8'd0 : pcnt;
        pass_final = !cont_q && (spcnt == rep_q);
`else
        pass_final = !cont_q;
`endif
    end

    // Control FSM, sample index, divider and all registered outputs.
    always_ff @(posedge dac_clk) begin
        if (!resetn) begin
            state     <= IDLE;
            start_q   <= '0;
            len_q     <= '0;
            div_q     <= '0;
            cont_q    <= 1'b0;
            idx       <= '0;
            div_cnt   <= '0;
            fin       <= 1'b0;
            cfg_ready <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass_end  <= 1'b0;
`ifdef DAC_SEQ_REPEAT_EN
            rep_q     <= 8'd0;
            pcnt      <= 8'd0;
`endif
        end else begin
            rd_en    <= 1'b0;
            pass_end <= 1'b0;
            done     <= 1'b0;

            case (state)
                IDLE: begin
                    cfg_ready <= 1'b1;
                    if (cfg_valid && cfg_ready) begin
                        start_q   <= cfg_start;
                        len_q     <= cfg_len;
                        div_q     <= cfg_div;
                        cont_q    <= cfg_cont;
`ifdef DAC_SEQ_REPEAT_EN
                        rep_q     <= cfg_repeat;
`endif
                        state     <= ARMED;
                        busy      <= 1'b1;
                        cfg_ready <= 1'b0;
                    end
                end
                ARMED: begin
                    if (stop) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                    end else if (trigger) begin
                        state   <= RUN;
                        div_cnt <= '0;
                        fin     <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                    end else if (fin) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (div_cnt == div_q) begin
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase

            if (strobe) begin
                rd_en   <= 1'b1;
                rd_addr <= start_q + sidx;
                if (last_smp) begin
                    pass_end <= 1'b1;
                    idx      <= '0;
                    if (pass_final) fin <= 1'b1;
`ifdef DAC_SEQ_REPEAT_EN
                    else pcnt <= spcnt + 8'd1;
`endif
                end else begin
                    idx <= sidx + ADDR_ONE;
`ifdef DAC_SEQ_REPEAT_EN
                    pcnt <= spcnt;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_dac_playback_sequencer.sv
// Directed bench for dac_playback_sequencer: per-cycle vector table plus corner sequences.
// Latency: inputs applied 1 time unit after an edge, outputs sampled 1 unit after the next edge.
// Backpressure: cfg handshakes exercised while busy; repeat sequence adapts to DAC_SEQ_REPEAT_EN.
module tb_dac_playback_sequencer;

    logic        dac_clk = 1'b0;
    logic        resetn;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_start;
    logic [15:0] cfg_len;
    logic [15:0] cfg_div;
    logic        cfg_cont;
    logic [7:0]  cfg_repeat;
    logic        trigger;
    logic        stop;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic        busy;
    logic        done;
    logic        pass_end;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 dac_clk = ~dac_clk;

    dac_playback_sequencer #(.ADDR_W(16), .DIV_W(16)) dut (
        .dac_clk    (dac_clk),
        .resetn     (resetn),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_start  (cfg_start),
        .cfg_len    (cfg_len),
        .cfg_div    (cfg_div),
        .cfg_cont   (cfg_cont),
`ifdef DAC_SEQ_REPEAT_EN
        .cfg_repeat (cfg_repeat),
`endif
        .trigger    (trigger),
        .stop       (stop),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .busy       (busy),
        .done       (done),
        .pass_end   (pass_end)
    );

    // expected/actual output word: {cfg_ready, busy, rd_en, pass_end, done, rd_addr}
    typedef struct {
        logic        cv;
        logic [15:0] st;
        logic [15:0] ln;
        logic [15:0] dv;
        logic        ct;
        logic        tr;
        logic        sp;
        logic [20:0] exp_out;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic cv, input logic [15:0] st, input logic [15:0] ln,
                                input logic [15:0] dv, input logic ct, input logic tr,
                                input logic sp, input logic rdy, input logic bsy,
                                input logic en, input logic pe, input logic dn,
                                input logic [15:0] addr);
        vec_t v;
        v.cv = cv; v.st = st; v.ln = ln; v.dv = dv; v.ct = ct; v.tr = tr; v.sp = sp;
        v.exp_out = {rdy, bsy, en, pe, dn, addr};
        return v;
    endfunction

    function automatic logic [20:0] outs();
        return {cfg_ready, busy, rd_en, pass_end, done, rd_addr};
    endfunction

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got rdy/busy/en/pe/done/addr=%b/%b/%b/%b/%b/%h, required %b/%b/%b/%b/%b/%h",
                     name, act[20], act[19], act[18], act[17], act[16], act[15:0],
                     exp_v[20], exp_v[19], exp_v[18], exp_v[17], exp_v[16], exp_v[15:0]);
        end
    endtask

    task automatic drive(input logic cv, input logic [15:0] st, input logic [15:0] ln,
                         input logic [15:0] dv, input logic ct, input logic tr, input logic sp);
        cfg_valid = cv; cfg_start = st; cfg_len = ln; cfg_div = dv; cfg_cont = ct;
        trigger = tr; stop = sp;
    endtask

    task automatic tick();
        @(posedge dac_clk);
        #1;
    endtask

    initial begin
        int strobes;
        int pes;
        int dones;
        int bad_addr;
        int exp_passes;

        resetn = 1'b0;
        cfg_repeat = 8'd0;
        drive(0, 0, 0, 0, 0, 0, 0);

        // one-shot start=0x0100 len=3 div=0
        tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(mk(1, 16'h0100, 3, 0, 0, 0, 0,  0, 1, 0, 0, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,         0, 1, 0, 0, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,         0, 1, 1, 0, 0, 16'h0100));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,         0, 1, 1, 0, 0, 16'h0101));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,         0, 1, 1, 0, 0, 16'h0102));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,         0, 1, 1, 1, 0, 16'h0103));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 1, 16'h0103));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,         1, 0, 0, 0, 0, 16'h0103));
        // one-shot start=0xFFFE len=3 div=2, address wrap
        tbl.push_back(mk(1, 16'hFFFE, 3, 2, 0, 0, 0,  0, 1, 0, 0, 0, 16'h0103));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,         0, 1, 1, 0, 0, 16'hFFFE));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,         0, 1, 0, 0, 0, 16'hFFFE));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,         0, 1, 0, 0, 0, 16'hFFFE));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,         0, 1, 1, 0, 0, 16'hFFFF));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,         0, 1, 0, 0, 0, 16'hFFFF));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,         0, 1, 0, 0, 0, 16'hFFFF));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,         0, 1, 1, 0, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,         0, 1, 0, 0, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,         0, 1, 0, 0, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,         0, 1, 1, 1, 0, 16'h0001));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 1, 16'h0001));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,         1, 0, 0, 0, 0, 16'h0001));
        // continuous start=0x10 len=1 div=1, stop suppresses a due strobe
        tbl.push_back(mk(1, 16'h0010, 1, 1, 1, 0, 0,  0, 1, 0, 0, 0, 16'h0001));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,         0, 1, 1, 0, 0, 16'h0010));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,         0, 1, 0, 0, 0, 16'h0010));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,         0, 1, 1, 1, 0, 16'h0011));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,         0, 1, 0, 0, 0, 16'h0011));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,         0, 1, 1, 0, 0, 16'h0010));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,         0, 1, 0, 0, 0, 16'h0010));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,         1, 0, 0, 0, 0, 16'h0010));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,         1, 0, 0, 0, 0, 16'h0010));
        // ARMED with trigger and stop together, then trigger in IDLE
        tbl.push_back(mk(1, 16'h0020, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 16'h0010));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1,         1, 0, 0, 0, 0, 16'h0010));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,         1, 0, 0, 0, 0, 16'h0010));
        // cfg_valid held high during RUN/DONE: no handshake until IDLE
        tbl.push_back(mk(1, 16'h0030, 2, 0, 0, 0, 0,  0, 1, 0, 0, 0, 16'h0010));
        tbl.push_back(mk(1, 16'h0050, 0, 0, 0, 1, 0,  0, 1, 1, 0, 0, 16'h0030));
        tbl.push_back(mk(1, 16'h0050, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 16'h0031));
        tbl.push_back(mk(1, 16'h0050, 0, 0, 0, 0, 0,  0, 1, 1, 1, 0, 16'h0032));
        tbl.push_back(mk(1, 16'h0050, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 16'h0032));
        tbl.push_back(mk(1, 16'h0050, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 16'h0032));
        tbl.push_back(mk(1, 16'h0050, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 16'h0032));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,         0, 1, 1, 1, 0, 16'h0050));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 1, 16'h0050));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,         1, 0, 0, 0, 0, 16'h0050));

        // reset state
        tick();
        tick();
        check("reset_state", outs(), 21'd0);

        resetn = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].cv, tbl[i].st, tbl[i].ln, tbl[i].dv, tbl[i].ct, tbl[i].tr, tbl[i].sp);
            tick();
            check($sformatf("vec%0d", i), outs(), tbl[i].exp_out);
        end

        // reset asserted in the middle of a continuous run
        drive(1, 16'h0040, 16'd5, 16'd0, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        tick();
        check("midrun_addr", outs(), {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0042});
        resetn = 1'b0; tick();
        check("midrun_reset", outs(), 21'd0);
        resetn = 1'b1; tick();
        check("after_reset_idle", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
        drive(0, 0, 0, 0, 0, 1, 0); tick();
        check("after_reset_trig_ignored", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});

        // one-shot passes: repeat=2, len=0
        cfg_repeat = 8'd2;
`ifdef DAC_SEQ_REPEAT_EN
        exp_passes = 3;
`else
        exp_passes = 1;
`endif
        drive(1, 16'h0077, 16'd0, 16'd0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        strobes = 0; pes = 0; dones = 0; bad_addr = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            drive(0, 0, 0, 0, 0, 0, 0);
            if (rd_en) begin
                strobes++;
                if (rd_addr !== 16'h0077) bad_addr++;
            end
            if (pass_end) pes++;
            if (done) dones++;
        end
        n_checks++;
        if (strobes != exp_passes) begin
            n_fail++;
            $display("FAIL repeat_strobes: got %0d, required %0d", strobes, exp_passes);
        end
        n_checks++;
        if (pes != exp_passes) begin
            n_fail++;
            $display("FAIL repeat_pass_end: got %0d, required %0d", pes, exp_passes);
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL repeat_done: got %0d, required 1", dones);
        end
        n_checks++;
        if (bad_addr != 0) begin
            n_fail++;
            $display("FAIL repeat_addr: got %0d wrong addresses, required 0", bad_addr);
        end
        check("repeat_final_idle", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0077});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
